// File: rtl/snake_scan_sched.sv
// snake_scan_sched
//   Owns a single-port segment RAM holding the snake body as a circular
//   buffer. Streams the body head-to-tail to the renderer once per scanline
//   and commits new heads requested by the game logic between scans.
//
// Ports
//   clk, rst_n, game_rst_n        clock, sync active-low resets (equivalent)
//   line_start                    per-scanline pulse; starts a body scan
//   move_req/move_x/move_y/grow   new-head request, held until move_ack
//   move_ack                      pulse in the cycle the head is written
//   mem_addr/mem_we/mem_wdata     segment RAM port, wdata = {y, x}
//   mem_rdata                     RAM read data, one cycle after mem_addr
//   snake_x/y/valid/first/last    segment stream, head first, tail last
//   snake_head_x/y                current head tile
//   length/full/overrun           segment count, length at max, sticky abort
module snake_scan_sched #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned START_X = 5,
  parameter int unsigned START_Y = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_rst_n,
  input  logic       line_start,
  input  logic       move_req,
  input  logic [4:0] move_x,
  input  logic [3:0] move_y,
  input  logic       grow,
  output logic       move_ack,
  output logic [4:0] mem_addr,
  output logic       mem_we,
  output logic [8:0] mem_wdata,
  input  logic [8:0] mem_rdata,
  output logic [4:0] snake_x,
  output logic [3:0] snake_y,
  output logic       snake_valid,
  output logic       snake_first,
  output logic       snake_last,
  output logic [4:0] snake_head_x,
  output logic [3:0] snake_head_y,
  output logic [5:0] length,
  output logic       full,
  output logic       overrun
);

  localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [5:0]  LEN_MAX = 6'(MAX_LEN);
  localparam logic [8:0]  START_W = {4'(START_Y), 5'(START_X)};

  typedef enum logic [1:0] {INIT, IDLE, SCAN, UPDATE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] head_ptr;
  logic [AW-1:0] head_nxt;
  logic [5:0]    scan_cnt;
  logic          ls_pend;
  logic          run;
  logic          issue, issue_first, issue_last;

  assign run      = rst_n & game_rst_n;
  assign head_nxt = head_ptr + 1'b1;
  assign full     = (length == LEN_MAX);

  // RAM data arrives the cycle after the address, alongside the registered
  // valid/first/last flags.
  assign snake_x = snake_valid ? mem_rdata[4:0] : '0;
  assign snake_y = snake_valid ? mem_rdata[8:5] : '0;

  always_comb begin
    state_nxt   = state;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    move_ack    = 1'b0;
    issue       = 1'b0;
    issue_first = 1'b0;
    issue_last  = 1'b0;
    case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_wdata = START_W;
        state_nxt = IDLE;
      end
      IDLE: begin
        mem_addr = 5'(head_ptr);
        if (line_start || ls_pend) state_nxt = SCAN;
        else if (move_req)         state_nxt = UPDATE;
      end
      SCAN: begin
        if (scan_cnt < length) begin
          // Address phase; a line_start here restarts from the head while
          // the address already issued still produces its beat.
          issue       = 1'b1;
          issue_first = (scan_cnt == 6'd0);
          issue_last  = (scan_cnt == 6'(length - 6'd1));
          mem_addr    = 5'(head_ptr - scan_cnt[AW-1:0]);
        end else begin
          // Drain cycle: final beat on the output, no new address.
          mem_addr  = 5'(head_ptr);
          state_nxt = line_start ? SCAN : IDLE;
        end
      end
      UPDATE: begin
        mem_addr  = 5'(head_nxt);
        mem_we    = 1'b1;
        mem_wdata = {move_y, move_x};
        move_ack  = 1'b1;
        state_nxt = (line_start || ls_pend) ? SCAN : IDLE;
      end
      default: state_nxt = INIT;
    endcase
    // A reset cycle discards whatever the state would have done.
    if (!run) begin
      mem_we   = 1'b0;
      move_ack = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      state        <= INIT;
      head_ptr     <= '0;
      length       <= 6'd1;
      snake_head_x <= 5'(START_X);
      snake_head_y <= 4'(START_Y);
      snake_valid  <= 1'b0;
      snake_first  <= 1'b0;
      snake_last   <= 1'b0;
      overrun      <= 1'b0;
      scan_cnt     <= '0;
      ls_pend      <= 1'b0;
    end else begin
      state       <= state_nxt;
      snake_valid <= issue;
      snake_first <= issue_first;
      snake_last  <= issue_last;

      if (state == INIT && line_start) ls_pend <= 1'b1;
      else if (state_nxt == SCAN)      ls_pend <= 1'b0;

      if (state == SCAN && issue) begin
        if (line_start) begin
          overrun  <= 1'b1;
          scan_cnt <= '0;
        end else begin
          scan_cnt <= scan_cnt + 6'd1;
        end
      end else begin
        scan_cnt <= '0;
      end

      if (state == UPDATE) begin
        head_ptr     <= head_nxt;
        snake_head_x <= move_x;
        snake_head_y <= move_y;
        if (grow && length < LEN_MAX) length <= length + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_snake_scan_sched.sv
module tb_snake_scan_sched;

  logic       clk = 1'b0;
  logic       rst_n, game_rst_n, line_start, move_req, grow;
  logic [4:0] move_x;
  logic [3:0] move_y;
  logic       move_ack;
  logic [4:0] mem_addr;
  logic       mem_we;
  logic [8:0] mem_wdata;
  logic [8:0] mem_rdata;
  logic [4:0] snake_x, snake_head_x;
  logic [3:0] snake_y, snake_head_y;
  logic       snake_valid, snake_first, snake_last;
  logic [5:0] length;
  logic       full, overrun;

  always #5 clk = ~clk;

  snake_scan_sched #(.MAX_LEN(32), .START_X(5), .START_Y(7)) dut (
    .clk(clk), .rst_n(rst_n), .game_rst_n(game_rst_n),
    .line_start(line_start), .move_req(move_req), .move_x(move_x),
    .move_y(move_y), .grow(grow), .move_ack(move_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .snake_x(snake_x), .snake_y(snake_y),
    .snake_valid(snake_valid), .snake_first(snake_first),
    .snake_last(snake_last), .snake_head_x(snake_head_x),
    .snake_head_y(snake_head_y), .length(length), .full(full),
    .overrun(overrun)
  );

  // Segment RAM: synchronous write, registered read
  logic [8:0] ram [32];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  int         nb, ack_c, hits;
  logic [4:0] bx [64];
  logic [3:0] by [64];
  logic       bf [64];
  logic       bl [64];
  logic [4:0] ex [64];
  logic [3:0] ey [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs ncyc cycles from a negedge. line_start pulses in iterations ls_a and
  // ls_b; move_req is held from iteration 0 until move_ack is seen. Beats and
  // the first ack cycle are recorded (sample c reflects state after posedge c).
  task automatic run(input int ls_a, input int ls_b, input bit mv,
                     input logic [4:0] x, input logic [3:0] y, input bit g,
                     input int ncyc);
    nb = 0;
    ack_c = -1;
    move_x = x;
    move_y = y;
    grow = g;
    for (int c = 0; c < ncyc; c++) begin
      line_start = (c == ls_a) || (c == ls_b);
      move_req = mv && (ack_c < 0);
      @(posedge clk);
      @(negedge clk);
      if (snake_valid && nb < 64) begin
        bx[nb] = snake_x;
        by[nb] = snake_y;
        bf[nb] = snake_first;
        bl[nb] = snake_last;
        nb++;
      end
      if (move_ack && ack_c < 0) ack_c = c;
    end
    line_start = 1'b0;
    move_req = 1'b0;
  endtask

  task automatic check_beats(input string tag, input int n);
    check({tag, "_count"}, nb, n);
    for (int k = 0; k < n && k < nb; k++) begin
      check({tag, "_x"}, bx[k], ex[k]);
      check({tag, "_y"}, by[k], ey[k]);
      check({tag, "_first"}, bf[k], k == 0);
      check({tag, "_last"}, bl[k], k == n - 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; game_rst_n = 1'b1; line_start = 1'b0; move_req = 1'b0;
    grow = 1'b0; move_x = '0; move_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_length", length, 1);
    check("rst_head_x", snake_head_x, 5);
    check("rst_head_y", snake_head_y, 7);
    check("rst_valid", snake_valid, 0);
    check("rst_we", mem_we, 0);
    check("rst_ack", move_ack, 0);
    check("rst_full", full, 0);
    check("rst_overrun", overrun, 0);

    // line_start during INIT is latched; single-segment scan
    rst_n = 1'b1;
    run(0, -1, 0, 0, 0, 0, 8);
    ex[0] = 5; ey[0] = 7;
    check_beats("scan1", 1);
    check("scan1_length", length, 1);

    // three growing moves
    for (int i = 0; i < 3; i++) begin
      run(-1, -1, 1, 5'(6 + i), 4'd7, 1, 2);
      check("grow_ack_c", ack_c, 0);
      check("grow_head_x", snake_head_x, 6 + i);
      check("grow_head_y", snake_head_y, 7);
      check("grow_length", length, 2 + i);
    end
    run(0, -1, 0, 0, 0, 0, 10);
    ex[0] = 8; ex[1] = 7; ex[2] = 6; ex[3] = 5;
    ey[0] = 7; ey[1] = 7; ey[2] = 7; ey[3] = 7;
    check_beats("scan4", 4);

    // non-growing move, line_start arriving during UPDATE
    run(1, -1, 1, 5'd9, 4'd7, 0, 10);
    check("move0_ack_c", ack_c, 0);
    check("move0_length", length, 4);
    ex[0] = 9; ex[1] = 8; ex[2] = 7; ex[3] = 6;
    check_beats("scan_upd", 4);

    // move_req with line_start in the same IDLE cycle: scan wins
    run(0, -1, 1, 5'd10, 4'd7, 0, 12);
    check_beats("scan_pend", 4);
    check("pend_ack_c", ack_c, 6);
    check("pend_head_x", snake_head_x, 10);
    check("pend_head_y", snake_head_y, 7);

    // fill to 32 then one extra grow
    for (int i = 0; i < 29; i++) begin
      run(-1, -1, 1, 5'(i), 4'd2, 1, 2);
      check("fill_ack_c", ack_c, 0);
      check("fill_length", length, (5 + i > 32) ? 32 : 5 + i);
      check("fill_full", full, i >= 27);
    end
    run(0, -1, 0, 0, 0, 0, 40);
    for (int k = 0; k < 29; k++) begin
      ex[k] = 5'(28 - k);
      ey[k] = 4'd2;
    end
    ex[29] = 10; ex[30] = 9; ex[31] = 8;
    ey[29] = 7;  ey[30] = 7; ey[31] = 7;
    check_beats("scan32", 32);
    hits = 0;
    for (int k = 0; k < nb; k++) if (bx[k] == 5'd5 && by[k] == 4'd7) hits++;
    check("scan32_start_absent", hits, 0);

    // re-pulse line_start two cycles into a scan
    run(0, 3, 0, 0, 0, 0, 45);
    check("abort_overrun", overrun, 1);
    check("abort_count", nb, 35);
    check("abort_b0_first", bf[0], 1);
    check("abort_b0_x", bx[0], 28);
    check("abort_b2_x", bx[2], 26);
    check("abort_b2_last", bl[2], 0);
    check("abort_b3_first", bf[3], 1);
    check("abort_b3_x", bx[3], 28);
    check("abort_b3_y", by[3], 2);
    check("abort_b34_last", bl[34], 1);
    check("abort_b34_x", bx[34], 8);
    check("abort_b34_y", by[34], 7);

    // game restart mid-scan
    run(0, -1, 0, 0, 0, 0, 3);
    game_rst_n = 1'b0;
    #1;
    check("grst_we_suppressed", mem_we, 0);
    @(posedge clk);
    @(negedge clk);
    check("grst_length", length, 1);
    check("grst_head_x", snake_head_x, 5);
    check("grst_head_y", snake_head_y, 7);
    check("grst_overrun", overrun, 0);
    check("grst_valid", snake_valid, 0);
    check("grst_full", full, 0);
    game_rst_n = 1'b1;
    #1;
    check("init_we", mem_we, 1);
    check("init_addr", mem_addr, 0);
    check("init_wdata", mem_wdata, 9'h0E5);
    run(2, -1, 0, 0, 0, 0, 8);
    ex[0] = 5; ey[0] = 7;
    check_beats("scan_after_grst", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snake_scan_sched.md
SNAKE_SCAN_SCHED -- requirements
Module: snake_scan_sched

Interface
REQ-001 Parameter MAX_LEN, default 32, maximum snake length in segments; SHALL be a power of two, 2..32.
REQ-002 Parameter START_X, default 5, tile column of the initial head.
REQ-003 Parameter START_Y, default 7, tile row of the initial head.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 game_rst_n  in  1  synchronous, active-low game restart; same effect as rst_n on this block.
REQ-007 line_start  in  1  one-cycle pulse per scanline from the sync generator.
REQ-008 move_req  in  1  game logic requests a new head; held until move_ack.
REQ-009 move_x / move_y  in  5 / 4  new head tile; stable while move_req is high.
REQ-010 grow  in  1  qualifies move_req: append the head without dropping the tail.
REQ-011 move_ack  out  1  one-cycle pulse in the cycle the head write occurs.
REQ-012 mem_addr / mem_we / mem_wdata  out  5 / 1 / 9  single-port segment RAM; wdata = {y[3:0], x[4:0]}.
REQ-013 mem_rdata  in  9  RAM read data, valid one cycle after mem_addr.
REQ-014 snake_x / snake_y / snake_valid  out  5 / 4 / 1  segment stream to the renderer.
REQ-015 snake_first / snake_last  out  1 / 1  marks the head and tail beats of the stream.
REQ-016 snake_head_x / snake_head_y  out  5 / 4  registered current head tile.
REQ-017 length  out  6  current segment count, 1..MAX_LEN.
REQ-018 full / overrun  out  1 / 1  length == MAX_LEN; sticky flag set when a scan is aborted.

Function
REQ-019 States: INIT, IDLE, SCAN, UPDATE; the RAM has exactly one owner per cycle.
REQ-020 INIT: write {START_Y, START_X} to address 0 with mem_we = 1 for one cycle, then go to IDLE.
REQ-021 IDLE + line_start: go to SCAN; line_start takes priority over a simultaneous move_req.
REQ-022 IDLE + move_req with no line_start: go to UPDATE.
REQ-023 SCAN: issue addresses head_ptr, head_ptr-1, ... (mod MAX_LEN) for length consecutive cycles.
REQ-024 SCAN: snake_valid is high for exactly length cycles, each one cycle after its address.
REQ-025 SCAN: snake_first is high on the first valid beat and snake_last on the final one; both are high on one beat when length = 1.
REQ-026 SCAN: return to IDLE in the cycle after the last beat; snake_valid, snake_first and snake_last are 0 outside valid beats.
REQ-027 line_start during SCAN: abort, set overrun, restart from head_ptr next cycle; the last beat of the aborted scan is still presented.
REQ-028 move_req during SCAN: held pending and serviced from IDLE after the scan, unless a line_start arrives in that same cycle.
REQ-029 UPDATE (one cycle): head_ptr <= head_ptr+1 mod MAX_LEN; write {move_y, move_x} at the new head_ptr; assert move_ack.
REQ-030 UPDATE: snake_head_x/y take move_x/y at the same edge; go to IDLE.
REQ-031 grow = 1 and length < MAX_LEN: length increments in UPDATE.
REQ-032 grow = 1 at length == MAX_LEN: length saturates; the oldest segment is overwritten.
REQ-033 grow = 0: length unchanged; the tail implicitly advances.
REQ-034 line_start during UPDATE: latched; SCAN begins in the cycle after UPDATE, and the scan reflects the new head.
REQ-035 mem_we is 1 only in INIT and UPDATE; in IDLE, mem_addr holds head_ptr.

Reset
REQ-036 While rst_n = 0 or game_rst_n = 0, at each edge the block SHALL set: state INIT; head_ptr 0; length 1; snake_head_x/y = START_X/START_Y.
REQ-037 Under the same condition it SHALL clear move_ack, snake_valid, snake_first, snake_last, mem_we, full and overrun.
REQ-038 A reset asserted mid-SCAN or mid-UPDATE SHALL discard the operation; the RAM write in that cycle is suppressed.
REQ-039 After reset releases, INIT SHALL complete before the first line_start is honoured; a line_start pulse arriving during INIT is latched.

Verification
REQ-040 Reset, then line_start -> one beat of (5,7) with first = last = valid = 1; length = 1.
REQ-041 Three moves with grow = 1 to (6,7), (7,7), (8,7), then line_start -> beats (8,7), (7,7), (6,7), (5,7); first on beat 1, last on beat 4.
REQ-042 Then a move with grow = 0 to (9,7) -> length stays 4; next scan = (9,7), (8,7), (7,7), (6,7).
REQ-043 move_req and line_start in the same IDLE cycle -> scan completes first; move_ack follows within length+2 cycles; head outputs update after the ack.
REQ-044 Fill to 32 with grow = 1, then one more grow -> length = 32, full = 1; the scan shows 32 beats, the new head first, and the original start segment absent.
REQ-045 line_start re-pulsed 2 cycles into a scan -> overrun = 1 and a full scan restarts; game_rst_n pulse mid-scan -> length = 1, head (5,7), overrun = 0.
